// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register file: the FSM state
// encoding, the register-pointer width helper and the PID gain slots.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      DEV_ACK,
      REG_ADDR,
      REG_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_state_e;

   // Register slots consumed by the PID core.
   localparam int P_IDX = 0;
   localparam int I_IDX = 1;
   localparam int D_IDX = 2;

   // Pointer width for a bank of n registers; never narrower than one bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers plus edge, START and STOP detection. All outputs
// are derived from the synchronised copies, so they are glitch-free in the
// clk domain.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Synchroniser chains plus one extra delayed copy for edge detection.
   // Everything resets to 1 so a released bus never looks like an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let each stage take the previous
         // stage's old value; blocking would collapse the chain to one flop.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  =  scl_s & ~scl_d;
   assign scl_fall  = ~scl_s &  scl_d;
   // SDA may only move while SCL is low, except for START and STOP.
   assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
   assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing NUM_REGS registers of DATA_WIDTH bits. Writes set the
// register pointer and then store bytes with auto-increment; reads return
// zero-extended registers MSB first. SDA is only ever pulled low (sda_oe).
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDRESS = 7'h33,
   parameter int         NUM_REGS       = 3,
   parameter int         DATA_WIDTH     = 6,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                ena,
   input  logic                                scl_in,
   input  logic                                sda_in,
   output logic                                sda_oe,
   output logic [NUM_REGS*DATA_WIDTH-1:0]      regs_flat,
   output logic                                wr_strobe,
   output logic [addr_width(NUM_REGS)-1:0]     wr_index,
   output logic                                busy
);

   localparam int             AW       = addr_width(NUM_REGS);
   localparam logic [AW-1:0]  PTR_LAST = AW'(NUM_REGS - 1);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_state_e              state, state_n;
   logic [3:0]              bit_cnt, bit_cnt_n;
   logic [7:0]              shift, shift_n;
   logic [AW-1:0]           ptr, ptr_n, ptr_inc;
   logic                    sda_oe_n, rw, rw_n, mnack, mnack_n, busy_n, commit;
   logic [7:0]              rd_byte, nxt_byte;
   logic                    byte_done;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

   // Next-state and datapath decode. Bus events take priority over the
   // per-state protocol: ena low, then STOP, then (repeated) START.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      ptr_n     = ptr;
      sda_oe_n  = sda_oe;
      rw_n      = rw;
      mnack_n   = mnack;
      busy_n    = busy;
      commit    = 1'b0;
      ptr_inc   = (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
      rd_byte   = '0;
      rd_byte[DATA_WIDTH-1:0]  = regs[ptr];
      nxt_byte  = '0;
      nxt_byte[DATA_WIDTH-1:0] = regs[ptr_inc];
      byte_done = scl_fall && (bit_cnt == 4'd8);

      if (!ena || stop_det) begin
         state_n   = IDLE;
         sda_oe_n  = 1'b0;
         bit_cnt_n = '0;
         busy_n    = 1'b0;
      end else if (start_det) begin
         state_n   = DEV_ADDR;
         sda_oe_n  = 1'b0;
         bit_cnt_n = '0;
      end else begin
         // Receive states shift one bit per SCL rise until the byte is full.
         if ((state == DEV_ADDR || state == REG_ADDR || state == WR_DATA) &&
             scl_rise && (bit_cnt != 4'd8)) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
         end
         case (state)
            DEV_ADDR: if (byte_done) begin
               bit_cnt_n = '0;
               rw_n      = shift[0];
               if (shift[7:1] == DEVICE_ADDRESS) begin
                  sda_oe_n = 1'b1;
                  busy_n   = 1'b1;
                  state_n  = DEV_ACK;
               end else begin
                  state_n  = WAIT_STOP;
               end
            end
            DEV_ACK: if (scl_fall) begin
               bit_cnt_n = '0;
               if (rw) begin
                  shift_n  = rd_byte;
                  sda_oe_n = ~rd_byte[7];
                  state_n  = RD_DATA;
               end else begin
                  sda_oe_n = 1'b0;
                  state_n  = REG_ADDR;
               end
            end
            REG_ADDR: if (byte_done) begin
               bit_cnt_n = '0;
               if (int'(shift) < NUM_REGS) begin
                  ptr_n    = shift[AW-1:0];
                  sda_oe_n = 1'b1;
                  state_n  = REG_ACK;
               end else begin
                  sda_oe_n = 1'b0;
                  state_n  = WAIT_STOP;
               end
            end
            REG_ACK: if (scl_fall) begin
               sda_oe_n = 1'b0;
               state_n  = WR_DATA;
            end
            WR_DATA: if (byte_done) begin
               bit_cnt_n = '0;
               sda_oe_n  = 1'b1;
               state_n   = WR_ACK;
            end
            // The byte is only committed once its ACK slot has completed.
            WR_ACK: if (scl_fall) begin
               commit   = 1'b1;
               ptr_n    = ptr_inc;
               sda_oe_n = 1'b0;
               state_n  = WR_DATA;
            end
            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt_n = '0;
                     sda_oe_n  = 1'b0;
                     state_n   = RD_ACK;
                  end else begin
                     shift_n  = {shift[6:0], 1'b0};
                     sda_oe_n = ~shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  mnack_n = sda_s;
               end else if (scl_fall) begin
                  if (!mnack) begin
                     ptr_n    = ptr_inc;
                     shift_n  = nxt_byte;
                     sda_oe_n = ~nxt_byte[7];
                     state_n  = RD_DATA;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WAIT_STOP;
                  end
               end
            end
            default: sda_oe_n = 1'b0;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Protocol datapath, SDA drive and the register bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shift     <= '0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         rw        <= 1'b0;
         mnack     <= 1'b1;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
         // NOTE: the bank is a handful of flops feeding live PID gains, so it
         // is reset like any other state; a RAM-style bank would not be.
         regs      <= '{default: '0};
      end else begin
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         ptr       <= ptr_n;
         sda_oe    <= sda_oe_n;
         rw        <= rw_n;
         mnack     <= mnack_n;
         busy      <= busy_n;
         wr_strobe <= commit;
         if (commit) begin
            regs[ptr] <= shift[DATA_WIDTH-1:0];
            wr_index  <= ptr;
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C master on a wired-AND SDA line drives
// the target and compares acknowledges, read data and the register bank
// against hand-computed values.
module tb_i2c_target_regfile;

   localparam int DW = 6;
   localparam int NR = 3;
   localparam int Q  = 10;   // clk cycles per quarter SCL period

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ena = 1'b0;
   logic              scl = 1'b1;
   logic              m_sda = 1'b1;
   logic              sda_oe, wr_strobe, busy;
   logic [NR*DW-1:0]  regs_flat;
   logic [1:0]        wr_index;
   wire               bus_sda = m_sda & ~sda_oe;

   int checks = 0;
   int errors = 0;
   int strobe_total = 0;

   always #5 clk = ~clk;

   i2c_target_regfile #(
      .DEVICE_ADDRESS (7'h33),
      .NUM_REGS       (NR),
      .DATA_WIDTH     (DW),
      .SYNC_STAGES    (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .scl_in    (scl),
      .sda_in    (bus_sda),
      .sda_oe    (sda_oe),
      .regs_flat (regs_flat),
      .wr_strobe (wr_strobe),
      .wr_index  (wr_index),
      .busy      (busy)
   );

   always @(negedge clk) if (wr_strobe) strobe_total++;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not complete, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   // START from idle, or repeated START with SCL low.
   task automatic bus_start();
      m_sda = 1'b1; wait_q();
      scl   = 1'b1; wait_q();
      m_sda = 1'b0; wait_q();
      scl   = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wait_q();
      scl   = 1'b1; wait_q();
      m_sda = 1'b1; wait_q();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         m_sda = b[7-i]; wait_q();
         scl   = 1'b1;   wait_q(); wait_q();
         scl   = 1'b0;   wait_q();
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      m_sda = 1'b1; wait_q();
      scl   = 1'b1; wait_q();
      ack   = bus_sda; wait_q();
      scl   = 1'b0; wait_q();
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         m_sda = 1'b1; wait_q();
         scl   = 1'b1; wait_q();
         b[7-i] = bus_sda; wait_q();
         scl   = 1'b0; wait_q();
      end
      m_sda = nack; wait_q();
      scl   = 1'b1; wait_q(); wait_q();
      scl   = 1'b0; wait_q();
      m_sda = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1; ena = 1'b1;
      wait_q();
      checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs: got %h required %h", regs_flat, 18'h0); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b required 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (wr_index !== 2'd0) begin errors++; $display("FAIL reset_wr_index: got %0d required 0", wr_index); end
   endtask

   task automatic test_single_write();
      logic a0, a1, a2;
      int   s0;
      s0 = strobe_total;
      bus_start();
      write_byte(8'h66, a0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
      write_byte(8'h01, a1);
      write_byte(8'h2A, a2);
      bus_stop(); wait_q();
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL single_acks: got %b required 000", {a0, a1, a2}); end
      checks++; if (regs_flat !== {6'h00, 6'h2A, 6'h00}) begin errors++; $display("FAIL single_regs: got %h required %h", regs_flat, {6'h00, 6'h2A, 6'h00}); end
      checks++; if (strobe_total - s0 !== 1) begin errors++; $display("FAIL single_strobes: got %0d required 1", strobe_total - s0); end
      checks++; if (wr_index !== 2'd1) begin errors++; $display("FAIL single_wr_index: got %0d required 1", wr_index); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_stop: got %b required 0", busy); end
   endtask

   task automatic test_burst_wrap();
      logic [7:0] bytes [6] = '{8'h66, 8'h00, 8'h11, 8'h22, 8'h33, 8'h3F};
      logic       ack;
      int         s0;
      s0 = strobe_total;
      bus_start();
      for (int i = 0; i < 6; i++) begin
         write_byte(bytes[i], ack);
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL burst_ack%0d: got %b required 0", i, ack); end
         if (i == 4) begin
            checks++; if (regs_flat !== {6'h33, 6'h22, 6'h11}) begin errors++; $display("FAIL burst_pre_wrap: got %h required %h", regs_flat, {6'h33, 6'h22, 6'h11}); end
         end
      end
      bus_stop(); wait_q();
      checks++; if (regs_flat !== {6'h33, 6'h22, 6'h3F}) begin errors++; $display("FAIL burst_wrap_regs: got %h required %h", regs_flat, {6'h33, 6'h22, 6'h3F}); end
      checks++; if (strobe_total - s0 !== 4) begin errors++; $display("FAIL burst_strobes: got %0d required 4", strobe_total - s0); end
      checks++; if (wr_index !== 2'd0) begin errors++; $display("FAIL burst_wr_index: got %0d required 0", wr_index); end
   endtask

   task automatic test_read_repeated_start();
      logic       a0, a1, a2;
      logic [7:0] d0, d1, d2;
      bus_start();
      write_byte(8'h66, a0);
      write_byte(8'h02, a1);
      bus_start();
      write_byte(8'h67, a2);
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks: got %b required 000", {a0, a1, a2}); end
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      checks++; if (d0 !== 8'h33) begin errors++; $display("FAIL read_reg2: got %h required 33", d0); end
      checks++; if (d1 !== 8'h3F) begin errors++; $display("FAIL read_reg0_wrap: got %h required 3f", d1); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_before_stop: got %b required 1", busy); end
      // After the NACK the target must stay off the bus until STOP.
      read_byte(1'b1, d2);
      checks++; if (d2 !== 8'hFF) begin errors++; $display("FAIL read_wait_stop_released: got %h required ff", d2); end
      bus_stop(); wait_q();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b required 0", busy); end
   endtask

   task automatic test_nack();
      logic a0, a1, a2, a3, a4;
      int   s0;
      s0 = strobe_total;
      bus_start();
      write_byte(8'h68, a0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_addr_busy: got %b required 0", busy); end
      write_byte(8'h01, a1);
      bus_stop();
      checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL nack_addr_mismatch: got %b required 11", {a0, a1}); end
      bus_start();
      write_byte(8'h66, a2);
      write_byte(8'h05, a3);
      write_byte(8'h15, a4);
      bus_stop(); wait_q();
      checks++; if ({a2, a3, a4} !== 3'b011) begin errors++; $display("FAIL nack_reg_range: got %b required 011", {a2, a3, a4}); end
      checks++; if (regs_flat !== {6'h33, 6'h22, 6'h3F}) begin errors++; $display("FAIL nack_regs_kept: got %h required %h", regs_flat, {6'h33, 6'h22, 6'h3F}); end
      checks++; if (strobe_total - s0 !== 0) begin errors++; $display("FAIL nack_strobes: got %0d required 0", strobe_total - s0); end
   endtask

   task automatic test_ena_abort();
      logic a0, a1, a2, a3, a4;
      int   s0;
      s0 = strobe_total;
      bus_start();
      write_byte(8'h66, a0);
      write_byte(8'h00, a1);
      send_bits(8'h15, 8);
      m_sda = 1'b1; wait_q();
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL ena_ack_driven: got %b required 1", sda_oe); end
      ena = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL ena_release: got %b required 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_busy: got %b required 0", busy); end
      scl = 1'b1; wait_q(); wait_q();
      scl = 1'b0; wait_q();
      ena = 1'b1;
      bus_stop(); wait_q();
      checks++; if (regs_flat !== {6'h33, 6'h22, 6'h3F}) begin errors++; $display("FAIL ena_no_commit: got %h required %h", regs_flat, {6'h33, 6'h22, 6'h3F}); end
      bus_start();
      write_byte(8'h66, a2);
      write_byte(8'h01, a3);
      write_byte(8'hC7, a4);
      bus_stop(); wait_q();
      checks++; if ({a2, a3, a4} !== 3'b000) begin errors++; $display("FAIL ena_recover_acks: got %b required 000", {a2, a3, a4}); end
      checks++; if (regs_flat !== {6'h33, 6'h07, 6'h3F}) begin errors++; $display("FAIL ena_recover_truncate: got %h required %h", regs_flat, {6'h33, 6'h07, 6'h3F}); end
      checks++; if (strobe_total - s0 !== 1) begin errors++; $display("FAIL ena_strobes: got %0d required 1", strobe_total - s0); end
      checks++; if (wr_index !== 2'd1) begin errors++; $display("FAIL ena_wr_index: got %0d required 1", wr_index); end
   endtask

   task automatic test_reset_abort();
      logic       a0, a1, a2, a3, a4, a5, a6;
      logic [7:0] d0;
      int         s0;
      bus_start();
      write_byte(8'h66, a0);
      write_byte(8'h02, a1);
      send_bits(8'h2A, 5);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (regs_flat !== '0) begin errors++; $display("FAIL rst_mid_regs: got %h required 0", regs_flat); end
      checks++; if ({sda_oe, busy} !== 2'b00) begin errors++; $display("FAIL rst_mid_outputs: got %b required 00", {sda_oe, busy}); end
      bus_stop(); wait_q();
      s0 = strobe_total;
      bus_start();
      write_byte(8'h66, a2);
      write_byte(8'h02, a3);
      write_byte(8'h3C, a4);
      bus_stop(); wait_q();
      checks++; if (regs_flat !== {6'h3C, 6'h00, 6'h00}) begin errors++; $display("FAIL rst_recover_regs: got %h required %h", regs_flat, {6'h3C, 6'h00, 6'h00}); end
      checks++; if (strobe_total - s0 !== 1) begin errors++; $display("FAIL rst_recover_strobes: got %0d required 1", strobe_total - s0); end
      checks++; if (wr_index !== 2'd2) begin errors++; $display("FAIL rst_recover_wr_index: got %0d required 2", wr_index); end
      // Address-only write followed by a repeated-START read of that register.
      bus_start();
      write_byte(8'h66, a5);
      write_byte(8'h02, a6);
      bus_start();
      write_byte(8'h67, a0);
      read_byte(1'b1, d0);
      bus_stop(); wait_q();
      checks++; if ({a2, a3, a4, a5, a6, a0} !== 6'b000000) begin errors++; $display("FAIL rst_recover_acks: got %b required 000000", {a2, a3, a4, a5, a6, a0}); end
      checks++; if (d0 !== 8'h3C) begin errors++; $display("FAIL rst_recover_read: got %h required 3c", d0); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_read_repeated_start();
      test_nack();
      test_ena_abort();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
